// File: rtl/shot_seq_pkg.sv
// Shared types and defaults for the shot sequencer.
// Contents: FSM state enum, default parameter values, and a helper that
// extracts one channel's delay from a packed delay bus.
package shot_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHARGE,
        RUN,
        DONE,
        ABORT
    } state_e;

    localparam int unsigned DEF_N_CH          = 4;
    localparam int unsigned DEF_CNT_W         = 16;
    localparam int unsigned DEF_CHARGE_TICKS  = 8;
    localparam int unsigned DEF_HOLD_CLKS     = 3;
    localparam int unsigned DEF_TIMEOUT_TICKS = 65600;

    // Upper bounds for the generic delay extractor below.
    localparam int unsigned MAX_CNT_W = 32;
    localparam int unsigned MAX_BUS_W = 1024;

    // Returns bits [k*w +: w] of bus, zero-extended to MAX_CNT_W.
    function automatic logic [MAX_CNT_W-1:0] ch_delay(
        input logic [MAX_BUS_W-1:0] bus,
        input int unsigned          k,
        input int unsigned          w
    );
        logic [MAX_BUS_W-1:0] shifted;
        logic [MAX_CNT_W-1:0] mask;
        shifted = bus >> (k * w);
        mask    = ~({MAX_CNT_W{1'b1}} << w);
        return shifted[MAX_CNT_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/shot_sequencer_channel.sv
// shot_channel: one output channel of the shot sequencer.
// Counts RUN ticks up to its delay, fires, holds its output for HOLD_CLKS
// clocks, then reports complete and stays quiet until re-armed.
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset
//   arm_i          : held during CHARGE; clears counter, presets complete
//   tick_i         : prescaler tick qualified with RUN
//   kill_i         : abort; drops the output immediately
//   en_i, delay_i  : shadowed enable and delay for this channel
//   out_o          : registered output / discharge drive
//   complete_o     : channel finished (or disabled)
module shot_channel
    import shot_seq_pkg::*;
#(
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned HOLD_CLKS = DEF_HOLD_CLKS
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             arm_i,
    input  logic             tick_i,
    input  logic             kill_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] delay_i,
    output logic             out_o,
    output logic             complete_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       hold_q;
    logic             out_q;
    logic             complete_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q      <= '0;
            hold_q     <= '0;
            out_q      <= 1'b0;
            complete_q <= 1'b0;
        end else if (arm_i) begin
            // Disabled channels are complete before RUN starts.
            cnt_q      <= '0;
            hold_q     <= '0;
            out_q      <= 1'b0;
            complete_q <= ~en_i;
        end else if (kill_i) begin
            hold_q <= '0;
            out_q  <= 1'b0;
        end else if (out_q) begin
            if (hold_q == 4'd1) begin
                out_q      <= 1'b0;
                hold_q     <= '0;
                complete_q <= 1'b1;
            end else begin
                hold_q <= hold_q - 4'd1;
            end
        end else if (tick_i && !complete_q) begin
            if (cnt_q == delay_i) begin
                out_q  <= 1'b1;
                hold_q <= 4'(HOLD_CLKS);
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign out_o      = out_q;
    assign complete_o = complete_q;

endmodule

// File: rtl/shot_sequencer.sv
// shot_sequencer: controls one firing cycle of the 4-channel delay generator.
// Start edge -> CHARGE for CHARGE_TICKS ticks -> RUN (per-channel delays and
// holds) -> DONE, or ABORT after TIMEOUT_TICKS RUN ticks.
// Ports:
//   i_clk, i_reset        : clock, synchronous active-high reset
//   i_tick                : one-cycle prescaler enable
//   i_start               : synchronised start level (rising edge starts)
//   i_ch_enable/i_ch_delay: configuration, shadowed at start
//   o_charge              : first-charge drive
//   o_out, o_discharge    : per-channel pulses (identical)
//   o_busy                : not IDLE
//   o_done, o_timeout     : one-cycle completion / abort pulses
module shot_sequencer
    import shot_seq_pkg::*;
#(
    parameter int unsigned N_CH          = DEF_N_CH,
    parameter int unsigned CNT_W         = DEF_CNT_W,
    parameter int unsigned CHARGE_TICKS  = DEF_CHARGE_TICKS,
    parameter int unsigned HOLD_CLKS     = DEF_HOLD_CLKS,
    parameter int unsigned TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_tick,
    input  logic                  i_start,
    input  logic [N_CH-1:0]       i_ch_enable,
    input  logic [N_CH*CNT_W-1:0] i_ch_delay,
    output logic                  o_charge,
    output logic [N_CH-1:0]       o_out,
    output logic [N_CH-1:0]       o_discharge,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_timeout
);

    localparam int unsigned TICK_MAX = (CHARGE_TICKS > TIMEOUT_TICKS) ? CHARGE_TICKS : TIMEOUT_TICKS;
    localparam int unsigned TICK_W   = $clog2(TICK_MAX + 1);

    state_e                state_q, state_d;
    logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
    logic [N_CH-1:0]       en_sh_q, en_sh_d;
    logic [N_CH*CNT_W-1:0] dly_sh_q, dly_sh_d;
    logic                  prev_start_q;
    logic                  charge_q, busy_q, done_q, timeout_q;

    logic                  start_edge;
    logic                  all_complete;
    logic                  ch_arm, ch_tick, ch_kill;
    logic [N_CH-1:0]       ch_out, ch_complete;

    assign start_edge   = i_start & ~prev_start_q;
    assign all_complete = &ch_complete;
    assign ch_arm       = (state_q == CHARGE);
    assign ch_tick      = (state_q == RUN) && i_tick;
    assign ch_kill      = (state_q == RUN) && (state_d == ABORT);

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        en_sh_d    = en_sh_q;
        dly_sh_d   = dly_sh_q;
        unique case (state_q)
            IDLE: begin
                if (start_edge && (|i_ch_enable)) begin
                    en_sh_d    = i_ch_enable;
                    dly_sh_d   = i_ch_delay;
                    tick_cnt_d = '0;
                    state_d    = CHARGE;
                end
            end
            CHARGE: begin
                if (i_tick) begin
                    if (tick_cnt_q == TICK_W'(CHARGE_TICKS - 1)) begin
                        tick_cnt_d = '0;
                        state_d    = RUN;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            RUN: begin
                // Completion is checked first so it wins over a coincident timeout.
                if (all_complete) begin
                    state_d = DONE;
                end else if (i_tick) begin
                    if (tick_cnt_q == TICK_W'(TIMEOUT_TICKS - 1)) begin
                        state_d = ABORT;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= IDLE;
            tick_cnt_q   <= '0;
            en_sh_q      <= '0;
            dly_sh_q     <= '0;
            prev_start_q <= 1'b1;
            charge_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            en_sh_q      <= en_sh_d;
            dly_sh_q     <= dly_sh_d;
            prev_start_q <= i_start;
            charge_q     <= (state_d == CHARGE);
            busy_q       <= (state_d != IDLE);
            done_q       <= (state_d == DONE);
            timeout_q    <= (state_d == ABORT);
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [CNT_W-1:0] delay_k;
        assign delay_k = CNT_W'(ch_delay(MAX_BUS_W'(dly_sh_q), k, CNT_W));

        shot_channel #(
            .CNT_W    (CNT_W),
            .HOLD_CLKS(HOLD_CLKS)
        ) u_ch (
            .clk_i     (i_clk),
            .reset_i   (i_reset),
            .arm_i     (ch_arm),
            .tick_i    (ch_tick),
            .kill_i    (ch_kill),
            .en_i      (en_sh_q[k]),
            .delay_i   (delay_k),
            .out_o     (ch_out[k]),
            .complete_o(ch_complete[k])
        );
    end

    assign o_charge    = charge_q;
    assign o_out       = ch_out;
    assign o_discharge = ch_out;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_shot_sequencer.sv
module tb_shot_sequencer;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_tick = 1'b0;
    logic        i_start = 1'b0;
    logic        i_start_to = 1'b0;
    logic [3:0]  i_ch_enable = '0;
    logic [63:0] i_ch_delay = '0;

    logic        charge0, busy0, done0, tmo0;
    logic [3:0]  out0, dis0;
    logic        charge1, busy1, done1, tmo1;
    logic [3:0]  out1, dis1;

    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    bit          mon_en = 1'b0;

    typedef struct {
        int unsigned dut;
        int unsigned cyc;
        logic [11:0] sig;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    shot_sequencer dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_tick     (i_tick),
        .i_start    (i_start),
        .i_ch_enable(i_ch_enable),
        .i_ch_delay (i_ch_delay),
        .o_charge   (charge0),
        .o_out      (out0),
        .o_discharge(dis0),
        .o_busy     (busy0),
        .o_done     (done0),
        .o_timeout  (tmo0)
    );

    shot_sequencer #(
        .TIMEOUT_TICKS(20)
    ) dut_to (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_tick     (i_tick),
        .i_start    (i_start_to),
        .i_ch_enable(i_ch_enable),
        .i_ch_delay (i_ch_delay),
        .o_charge   (charge1),
        .o_out      (out1),
        .o_discharge(dis1),
        .o_busy     (busy1),
        .o_done     (done1),
        .o_timeout  (tmo1)
    );

    // Signature layout: {busy, charge, done, timeout, out[3:0], discharge[3:0]}
    function automatic logic [11:0] mk(input logic busy, input logic charge,
                                       input logic done, input logic tmo,
                                       input logic [3:0] out);
        return {busy, charge, done, tmo, out, out};
    endfunction

    // Edge number of the j-th RUN tick (j=0 gives the 8th CHARGE tick) for a
    // start sampled at edge s; ticks are sampled on edges that are multiples of 4.
    function automatic int unsigned rtick(input int unsigned s, input int unsigned j);
        int unsigned t1;
        t1 = (s / 4 + 1) * 4;
        return t1 + 28 + 4 * j;
    endfunction

    task automatic push(input int unsigned d, input int unsigned c, input logic [11:0] sg);
        exp_t e;
        e.dut = d;
        e.cyc = c;
        e.sig = sg;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        i_tick = ((cyc + 1) % 4 == 0);
    endtask

    task automatic run_to(input int unsigned c);
        while (cyc < c) step();
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cyc %0d)", name, got, req, cyc);
        end
    endtask

    // Monitor: every change of a DUT's output signature must match the next
    // expected entry in dut id, cycle and value.
    logic [11:0] cur [2];
    logic [11:0] prev [2] = '{12'h000, 12'h000};

    always @(negedge clk) begin
        if (mon_en) begin
            cur[0] = {busy0, charge0, done0, tmo0, out0, dis0};
            cur[1] = {busy1, charge1, done1, tmo1, out1, dis1};
            for (int d = 0; d < 2; d++) begin
                if (cur[d] !== prev[d]) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_change: dut %0d cyc %0d got %b required no change",
                                 d, cyc, cur[d]);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        if (e.dut != d || e.cyc != cyc || e.sig !== cur[d]) begin
                            n_fail++;
                            $display("FAIL output_change: got dut %0d cyc %0d sig %b required dut %0d cyc %0d sig %b",
                                     d, cyc, cur[d], e.dut, e.cyc, e.sig);
                        end
                    end
                    prev[d] = cur[d];
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion (cyc %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned s;
        int unsigned r;
        int unsigned r2;

        // Reset state
        repeat (3) step();
        check("reset_busy", 32'(busy0), 32'd0);
        check("reset_charge", 32'(charge0), 32'd0);
        check("reset_done", 32'(done0), 32'd0);
        check("reset_timeout", 32'(tmo0), 32'd0);
        check("reset_out", 32'(out0), 32'd0);
        check("reset_discharge", 32'(dis0), 32'd0);
        check("reset_busy_to", 32'(busy1), 32'd0);
        i_reset = 1'b0;
        mon_en  = 1'b1;
        repeat (3) step();

        // Two channels, delays ch0=3 and ch2=0
        i_ch_enable = 4'b0101;
        i_ch_delay  = {16'd0, 16'd0, 16'd0, 16'd3};
        i_start     = 1'b1;
        s = cyc + 1;
        r  = rtick(s, 1);
        r2 = rtick(s, 4);
        push(0, s,        mk(1, 1, 0, 0, 4'b0000));
        push(0, rtick(s, 0), mk(1, 0, 0, 0, 4'b0000));
        push(0, r,        mk(1, 0, 0, 0, 4'b0100));
        push(0, r + 3,    mk(1, 0, 0, 0, 4'b0000));
        push(0, r2,       mk(1, 0, 0, 0, 4'b0001));
        push(0, r2 + 3,   mk(1, 0, 0, 0, 4'b0000));
        push(0, r2 + 4,   mk(1, 0, 1, 0, 4'b0000));
        push(0, r2 + 5,   mk(0, 0, 0, 0, 4'b0000));
        run_to(r2 + 8);
        i_start = 1'b0;
        repeat (2) step();

        // Start edge with no channel enabled, then start held through reset
        i_ch_enable = 4'b0000;
        i_start = 1'b1;
        repeat (10) step();
        check("no_enable_busy", 32'(busy0), 32'd0);
        i_start = 1'b0;
        step();
        i_ch_enable = 4'b0001;
        i_ch_delay  = {16'd0, 16'd0, 16'd0, 16'd2};
        i_reset = 1'b1;
        i_start = 1'b1;
        repeat (3) step();
        i_reset = 1'b0;
        repeat (12) step();
        check("start_through_reset_busy", 32'(busy0), 32'd0);
        check("start_through_reset_charge", 32'(charge0), 32'd0);
        i_start = 1'b0;
        repeat (2) step();

        // Delay 100 with a second start edge and reconfiguration mid-RUN
        i_ch_enable = 4'b0001;
        i_ch_delay  = {16'd0, 16'd0, 16'd0, 16'd100};
        i_start = 1'b1;
        s  = cyc + 1;
        r2 = rtick(s, 101);
        push(0, s,           mk(1, 1, 0, 0, 4'b0000));
        push(0, rtick(s, 0), mk(1, 0, 0, 0, 4'b0000));
        push(0, r2,          mk(1, 0, 0, 0, 4'b0001));
        push(0, r2 + 3,      mk(1, 0, 0, 0, 4'b0000));
        push(0, r2 + 4,      mk(1, 0, 1, 0, 4'b0000));
        push(0, r2 + 5,      mk(0, 0, 0, 0, 4'b0000));
        run_to(rtick(s, 10));
        i_start = 1'b0;
        step();
        i_start = 1'b1;
        i_ch_delay  = {16'd5, 16'd5, 16'd5, 16'd5};
        i_ch_enable = 4'b1111;
        run_to(r2 + 8);
        i_start = 1'b0;
        repeat (2) step();

        // Timeout instance: delay 50 against a 20-tick limit
        i_ch_enable = 4'b0001;
        i_ch_delay  = {16'd0, 16'd0, 16'd0, 16'd50};
        i_start_to = 1'b1;
        s = cyc + 1;
        r = rtick(s, 20);
        push(1, s,           mk(1, 1, 0, 0, 4'b0000));
        push(1, rtick(s, 0), mk(1, 0, 0, 0, 4'b0000));
        push(1, r,           mk(1, 0, 0, 1, 4'b0000));
        push(1, r + 1,       mk(0, 0, 0, 0, 4'b0000));
        run_to(r + 40);
        i_start_to = 1'b0;
        check("timeout_busy_idle", 32'(busy1), 32'd0);
        repeat (2) step();

        // Reset during a channel hold
        i_ch_enable = 4'b0001;
        i_ch_delay  = {16'd0, 16'd0, 16'd0, 16'd2};
        i_start = 1'b1;
        s = cyc + 1;
        r = rtick(s, 3);
        push(0, s,           mk(1, 1, 0, 0, 4'b0000));
        push(0, rtick(s, 0), mk(1, 0, 0, 0, 4'b0000));
        push(0, r,           mk(1, 0, 0, 0, 4'b0001));
        push(0, r + 1,       mk(0, 0, 0, 0, 4'b0000));
        run_to(r);
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        i_start = 1'b0;
        check("mid_hold_reset_out", 32'(out0), 32'd0);
        check("mid_hold_reset_busy", 32'(busy0), 32'd0);
        repeat (2) step();

        // All four channels with delay 7 fire together
        i_ch_enable = 4'b1111;
        i_ch_delay  = {16'd7, 16'd7, 16'd7, 16'd7};
        i_start = 1'b1;
        s = cyc + 1;
        r = rtick(s, 8);
        push(0, s,           mk(1, 1, 0, 0, 4'b0000));
        push(0, rtick(s, 0), mk(1, 0, 0, 0, 4'b0000));
        push(0, r,           mk(1, 0, 0, 0, 4'b1111));
        push(0, r + 3,       mk(1, 0, 0, 0, 4'b0000));
        push(0, r + 4,       mk(1, 0, 1, 0, 4'b0000));
        push(0, r + 5,       mk(0, 0, 0, 0, 4'b0000));
        run_to(r + 10);
        i_start = 1'b0;
        repeat (4) step();

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_events: got %0d unseen required 0 (next cyc %0d)",
                     exp_q.size(), exp_q[0].cyc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
